// File: rtl/lift_call_dispatcher.sv
// Lift call dispatcher: latches floor calls, tracks the car floor and issues SCAN-ordered HOLD/UP/DOWN commands.
// Defining LIFT_DISPATCH_EMERG_EN adds the emerg input and an EMERG recall-to-ground state.
module lift_call_dispatcher #(
  parameter int NUM_FLOORS  = 8,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [2:0]            floor,
`ifdef LIFT_DISPATCH_EMERG_EN
  input  logic                  emerg,
`endif
  output logic [1:0]            in,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MOVE_UP   = 3'd1;
  localparam logic [2:0] MOVE_DOWN = 3'd2;
  localparam logic [2:0] DOOR      = 3'd3;
`ifdef LIFT_DISPATCH_EMERG_EN
  localparam logic [2:0] EMERG     = 3'd4;
`endif

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b11;

  // The door counter only ever holds DOOR_CYCLES-1 down to 0.
  localparam int             CW        = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]  DOOR_LOAD = CW'(DOOR_CYCLES - 1);

  logic [2:0]            state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  dir_up, dir_up_d;
  logic [1:0]            in_d;
  logic                  door_d, served_d;
  logic [NUM_FLOORS-1:0] here_mask, above_mask, below_mask;
  logic [NUM_FLOORS-1:0] clear_mask, accept_mask, pending_d;
  logic                  floor_ok, at_call, calls_above, calls_below, absorb;

  always_comb begin
    here_mask  = '0;
    above_mask = '0;
    below_mask = '0;
    floor_ok   = int'(floor) < NUM_FLOORS;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_mask[i]  = floor_ok && (int'(floor) == i);
      above_mask[i] = floor_ok && (i > int'(floor));
      below_mask[i] = floor_ok && (i < int'(floor));
    end
    at_call     = |(pending & here_mask);
    calls_above = |(pending & above_mask);
    calls_below = |(pending & below_mask);
    // A button pressed at the floor where the car already waits is served on the spot.
    absorb      = ((state == IDLE) || (state == DOOR)) && |(call_req & here_mask);
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    dir_up_d   = dir_up;
    in_d       = CMD_HOLD;
    door_d     = 1'b0;
    served_d   = 1'b0;
    clear_mask = '0;

    if (!floor_ok) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (absorb || at_call) begin
            state_d    = DOOR;
            cnt_d      = DOOR_LOAD;
            door_d     = 1'b1;
            served_d   = 1'b1;
            clear_mask = here_mask;
          end else if (calls_above && (!calls_below || dir_up)) begin
            state_d = MOVE_UP;
            in_d    = CMD_UP;
          end else if (calls_below) begin
            state_d = MOVE_DOWN;
            in_d    = CMD_DOWN;
          end
        end
        MOVE_UP: begin
          dir_up_d = 1'b1;
          if (at_call) begin
            state_d    = DOOR;
            cnt_d      = DOOR_LOAD;
            door_d     = 1'b1;
            served_d   = 1'b1;
            clear_mask = here_mask;
          end else if (calls_above) begin
            in_d = CMD_UP;
          end else if (calls_below) begin
            state_d = MOVE_DOWN;
            in_d    = CMD_DOWN;
          end else begin
            state_d = IDLE;
          end
        end
        MOVE_DOWN: begin
          dir_up_d = 1'b0;
          if (at_call) begin
            state_d    = DOOR;
            cnt_d      = DOOR_LOAD;
            door_d     = 1'b1;
            served_d   = 1'b1;
            clear_mask = here_mask;
          end else if (calls_below) begin
            in_d = CMD_DOWN;
          end else if (calls_above) begin
            state_d = MOVE_UP;
            in_d    = CMD_UP;
          end else begin
            state_d = IDLE;
          end
        end
        DOOR: begin
          door_d = 1'b1;
          // Reloading keeps the door open for a full DOOR_CYCLES after the latest press.
          if (absorb) begin
            cnt_d    = DOOR_LOAD;
            served_d = 1'b1;
          end else if (cnt == '0) begin
            state_d = IDLE;
            door_d  = 1'b0;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef LIFT_DISPATCH_EMERG_EN
    // Emergency recall overrides everything: drive to ground, open the door and drop all calls.
    if (emerg) begin
      state_d    = EMERG;
      cnt_d      = '0;
      served_d   = 1'b0;
      clear_mask = '1;
      in_d       = (floor == 3'd0) ? CMD_HOLD : CMD_DOWN;
      door_d     = (floor == 3'd0);
    end else if (state == EMERG) begin
      state_d    = IDLE;
      served_d   = 1'b0;
      clear_mask = '1;
      in_d       = CMD_HOLD;
      door_d     = 1'b0;
    end
`endif
  end

  assign accept_mask = call_req & ~(absorb ? here_mask : '0);
  assign pending_d   = (pending | accept_mask) & ~clear_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_up    <= 1'b1;
      in        <= CMD_HOLD;
      door_open <= 1'b0;
      pending   <= '0;
      served    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dir_up    <= dir_up_d;
      in        <= in_d;
      door_open <= door_d;
      pending   <= pending_d;
      served    <= served_d;
    end
  end

endmodule

// File: tb/tb_lift_call_dispatcher.sv
// Bench for lift_call_dispatcher: directed scenarios plus random calls against a floor-list reference model.
// The lift is modelled as one floor step per cycle, applied on the falling clock edge.
module tb_lift_call_dispatcher;

  localparam int NF = 8;
  localparam int DC = 3;
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_req;
  logic [2:0]    floor;
  logic [1:0]    in;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          served;

  logic [5:0]    call6, pending6;
  logic [2:0]    floor6;
  logic [1:0]    in6;
  logic          door6, served6;
`ifdef LIFT_DISPATCH_EMERG_EN
  logic          emerg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lift_call_dispatcher #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .floor     (floor),
`ifdef LIFT_DISPATCH_EMERG_EN
    .emerg     (emerg),
`endif
    .in        (in),
    .door_open (door_open),
    .pending   (pending),
    .served    (served)
  );

  lift_call_dispatcher #(.NUM_FLOORS(6), .DOOR_CYCLES(DC)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call6),
    .floor     (floor6),
`ifdef LIFT_DISPATCH_EMERG_EN
    .emerg     (1'b0),
`endif
    .in        (in6),
    .door_open (door6),
    .pending   (pending6),
    .served    (served6)
  );

  // Reference model: list of requested floors, travel mode, last direction and door time left.
  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
  mode_t      mode;
  bit         mp[NF];
  bit         last_up;
  int         door_left;
  logic [1:0] e_in;
  bit         e_door, e_served;
  int         served_floors[$];

  function automatic logic [NF-1:0] pend_vec();
    logic [NF-1:0] v = '0;
    for (int g = 0; g < NF; g++) v[g] = mp[g];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic open_door_here(input int f);
    mode      = M_DOOR;
    door_left = DC;
    e_door    = 1'b1;
    e_served  = 1'b1;
    mp[f]     = 1'b0;
  endtask

  task automatic model_step(input logic [NF-1:0] cr, input logic [2:0] fl, input logic rst_n);
    int f;
    bit above, below, here, absorb;
    e_in = HOLD; e_door = 1'b0; e_served = 1'b0;
    if (!rst_n) begin
      mode = M_IDLE; last_up = 1'b1; door_left = 0;
      for (int g = 0; g < NF; g++) mp[g] = 1'b0;
      return;
    end
    f = int'(fl);
    above = 1'b0; below = 1'b0;
    for (int g = 0; g < NF; g++) begin
      if (mp[g] && g > f) above = 1'b1;
      if (mp[g] && g < f) below = 1'b1;
    end
    here   = mp[f];
    absorb = (mode == M_IDLE || mode == M_DOOR) && cr[f];
    for (int g = 0; g < NF; g++)
      if (cr[g] && !(absorb && g == f)) mp[g] = 1'b1;
    case (mode)
      M_IDLE: begin
        if (here || absorb) open_door_here(f);
        else if (above && (!below || last_up)) begin mode = M_UP; e_in = UP; end
        else if (below) begin mode = M_DOWN; e_in = DOWN; end
      end
      M_UP: begin
        last_up = 1'b1;
        if (here) open_door_here(f);
        else if (above) e_in = UP;
        else if (below) begin mode = M_DOWN; e_in = DOWN; end
        else mode = M_IDLE;
      end
      M_DOWN: begin
        last_up = 1'b0;
        if (here) open_door_here(f);
        else if (below) e_in = DOWN;
        else if (above) begin mode = M_UP; e_in = UP; end
        else mode = M_IDLE;
      end
      M_DOOR: begin
        e_door = 1'b1;
        if (absorb) begin door_left = DC; e_served = 1'b1; end
        else begin
          door_left--;
          if (door_left == 0) begin mode = M_IDLE; e_door = 1'b0; end
        end
      end
    endcase
  endtask

  // One clock of the main DUT: predict, clock, compare, then let the lift move.
  task automatic applyStimulus();
    model_step(call_req, floor, reset);
    @(posedge clk); #1;
    checkOutput();
    if (served === 1'b1) served_floors.push_back(int'(floor));
    @(negedge clk);
    if (in == UP && floor < 3'(NF - 1)) floor = floor + 3'd1;
    else if (in == DOWN && floor > 3'd0) floor = floor - 3'd1;
  endtask

  task automatic checkOutput();
    chk("in", 32'(in), 32'(e_in));
    chk("door_open", 32'(door_open), 32'(e_door));
    chk("pending", 32'(pending), 32'(pend_vec()));
    chk("served", 32'(served), 32'(e_served));
    chk("no_up_at_top", 32'((floor == 3'(NF - 1)) && (in == UP)), 0);
    chk("no_move_door_open", 32'(door_open && (in != HOLD)), 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_until_idle(input string tag, input int budget, output int door_cycles);
    bit done = 1'b0;
    door_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      applyStimulus();
      if (door_open) door_cycles++;
      if (mode == M_IDLE && pend_vec() == '0) begin done = 1'b1; break; end
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    int dcyc;
    bit reached;

    reset = 1'b0; call_req = '1; floor = 3'd0; call6 = '0; floor6 = 3'd0;
`ifdef LIFT_DISPATCH_EMERG_EN
    emerg = 1'b0;
`endif
    applyStimulus();
    applyStimulus();
    chk("reset_pending", 32'(pending), 0);
    reset = 1'b1; call_req = '0;
    applyStimulus();
    applyStimulus();

    // Single up call from floor 0 to floor 3.
    call_req = 8'h08;
    applyStimulus();
    chk("up_latch", 32'(pending), 32'h08);
    call_req = '0;
    applyStimulus();
    chk("up_cmd", 32'(in), 32'(UP));
    run_until_idle("up_timeout", 40, dcyc);
    chk("up_door_len", 32'(dcyc), DC);
    chk("up_stop_floor", 32'(floor), 3);

    // SCAN: heading up from floor 2 with calls at 5 and 0.
    floor = 3'd2;
    served_floors.delete();
    call_req = 8'h20;
    applyStimulus();
    call_req = 8'h01;
    applyStimulus();
    call_req = '0;
    chk("scan_pending", 32'(pending), 32'h21);
    run_until_idle("scan_timeout", 60, dcyc);
    chk("scan_served_n", 32'(served_floors.size()), 2);
    chk("scan_first", 32'((served_floors.size() > 0) ? served_floors[0] : 99), 5);
    chk("scan_second", 32'((served_floors.size() > 1) ? served_floors[1] : 99), 0);

    // Door at floor 4, then the same button again while open.
    call_req = 8'h10;
    applyStimulus();
    call_req = '0;
    reached = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (mode == M_DOOR) begin reached = 1'b1; break; end
    end
    chk("door4_reached", 32'(reached), 1);
    applyStimulus();
    call_req = 8'h10;
    applyStimulus();
    call_req = '0;
    chk("absorb_served", 32'(served), 1);
    chk("absorb_not_latched", 32'(pending), 0);
    run_until_idle("absorb_timeout", 20, dcyc);
    chk("absorb_hold_after", 32'(dcyc), DC - 1);

    // Top floor call, then a press at the top while parked there.
    call_req = 8'h80;
    applyStimulus();
    call_req = '0;
    run_until_idle("top_timeout", 40, dcyc);
    chk("top_floor", 32'(floor), 7);
    call_req = 8'h80;
    applyStimulus();
    call_req = '0;
    chk("top_absorb", 32'(served), 1);
    run_until_idle("top2_timeout", 20, dcyc);

    // Random call traffic, then drain.
    for (int i = 0; i < 400; i++) begin
      call_req = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
      applyStimulus();
    end
    call_req = '0;
    run_until_idle("drain_timeout", 300, dcyc);
    chk("drain_pending", 32'(pending), 0);

    // Six-floor instance: floor code 7 is invalid.
    call6 = 6'h10;
    tick();
    chk("inv_latch", 32'(pending6), 32'h10);
    call6 = '0;
    tick();
    chk("inv_up", 32'(in6), 32'(UP));
    floor6 = 3'd7;
    tick();
    chk("inv_hold", 32'(in6), 32'(HOLD));
    chk("inv_door", 32'(door6), 0);
    chk("inv_keep", 32'(pending6), 32'h10);
    tick();
    chk("inv_hold2", 32'(in6), 32'(HOLD));
    chk("inv_keep2", 32'(pending6), 32'h10);
    floor6 = 3'd2;
    tick();
    chk("inv_resume", 32'(in6), 32'(UP));
    floor6 = 3'd4;
    tick();
    chk("inv_arrive_in", 32'(in6), 32'(HOLD));
    chk("inv_arrive_served", 32'(served6), 1);
    chk("inv_arrive_door", 32'(door6), 1);
    chk("inv_arrive_pending", 32'(pending6), 0);

`ifdef LIFT_DISPATCH_EMERG_EN
    // Emergency recall from floor 5 with a call to floor 7 outstanding.
    floor = 3'd5;
    call_req = 8'h80;
    applyStimulus();
    call_req = '0;
    emerg = 1'b1;
    tick();
    chk("emerg_clear", 32'(pending), 0);
    chk("emerg_down", 32'(in), 32'(DOWN));
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in == HOLD && door_open) begin reached = 1'b1; break; end
      chk("emerg_cmd", 32'(in), 32'(DOWN));
      @(negedge clk);
      if (in == DOWN && floor > 3'd0) floor = floor - 3'd1;
      tick();
    end
    chk("emerg_reached", 32'(reached), 1);
    chk("emerg_floor", 32'(floor), 0);
    call_req = '1;
    tick();
    tick();
    chk("emerg_ignore", 32'(pending), 0);
    chk("emerg_door", 32'(door_open), 1);
    chk("emerg_hold", 32'(in), 32'(HOLD));
    emerg = 1'b0;
    call_req = '0;
    tick();
    chk("emerg_exit_door", 32'(door_open), 0);
    chk("emerg_exit_in", 32'(in), 32'(HOLD));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
